pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised hazard controller for the 5-stage RV32I pipeline. It generates EX-stage operand forwarding selects, load-use and no-forwarding RAW stalls, and control-transfer flushes for branches and jumps resolved in MEM. It also runs a wait-state FSM for a variable-latency data memory, with a timeout error flag and saturating performance counters. It sits beside the pipeline top and drives the stall/flush enables of every pipeline register.

Parameters:
REG_AW, 5, register address width
FWD_EN, 1, 1 = forwarding plus load-use stall; 0 = no forwarding, stall on any RAW
TIMEOUT, 64, max MEM wait cycles before mem_err_o is set (>=2)
CNT_W, 16, performance counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rs1_d_i, rs2_d_i  in  REG_AW  source registers in ID
rs1_e_i, rs2_e_i  in  REG_AW  source registers in EX
rd_e_i  in  REG_AW  destination in EX
regwrite_e_i  in  1  EX writes rd
memread_e_i  in  1  EX instruction is a load
rd_m_i  in  REG_AW  destination in MEM
regwrite_m_i  in  1  MEM writes rd
rd_w_i  in  REG_AW  destination in WB
regwrite_w_i  in  1  WB writes rd
redirect_m_i  in  1  taken branch/jump/return in MEM
dmem_req_m_i  in  1  MEM issues a load/store
dmem_ready_m_i  in  1  data memory completes this cycle
fwd_a_o, fwd_b_o  out  2  00 = regfile, 01 = WB result, 10 = MEM ALU result
stall_f_o, stall_d_o, stall_e_o, stall_m_o  out  1  hold PC / IF-ID / ID-EX / EX-MEM registers
flush_d_o, flush_e_o, flush_m_o, flush_w_o  out  1  insert bubble into IF-ID / ID-EX / EX-MEM / MEM-WB
mem_err_o  out  1  sticky memory timeout
stall_cnt_o  out  CNT_W  cycles with stall_f_o high
flush_cnt_o  out  CNT_W  accepted redirects

Behaviour:
- Stall, flush and forward outputs are combinational from the inputs and FSM state. FSM state, timer, counters and mem_err_o are registered.
- Reset (async, rst_ni low): FSM IDLE, wait timer 0, counters 0, mem_err_o 0.
- Register x0 never matches any comparison.
- Forwarding, FWD_EN=1:
  - fwd_a_o = 10 if regwrite_m_i && rd_m_i==rs1_e_i; else 01 if regwrite_w_i && rd_w_i==rs1_e_i; else 00. MEM has priority over WB.
  - fwd_b_o is the same rule using rs2_e_i.
- Forwarding, FWD_EN=0: fwd_a_o = fwd_b_o = 00 always.
- Data hazard (haz):
  - FWD_EN=1: memread_e_i && rd_e_i matches rs1_d_i or rs2_d_i.
  - FWD_EN=0: any writer in EX, MEM or WB with rd matching rs1_d_i or rs2_d_i.
  - Response: stall_f_o = stall_d_o = 1, flush_e_o = 1. The condition re-evaluates each cycle.
- MEM wait FSM, states IDLE and WAIT:
  - mwait = dmem_req_m_i && !dmem_ready_m_i.
  - IDLE -> WAIT on mwait. WAIT -> IDLE when dmem_ready_m_i.
  - While mwait (either state): stall_f/d/e/m_o = 1 and flush_w_o = 1. All other flushes are 0 and haz is ignored.
  - The ready cycle itself is not stalled.
  - Timer counts cycles in WAIT. Reaching TIMEOUT-1 sets mem_err_o (sticky); the FSM keeps waiting.
- Redirect (redirect_m_i && !mwait):
  - flush_d_o = flush_e_o = flush_m_o = 1 for that cycle. PC is not stalled.
  - Redirect overrides haz: no stall, because the stalled instruction is being flushed.
- A redirect held during mwait takes effect on the ready cycle.
- Priority order: mwait > redirect > haz.
- Counters:
  - stall_cnt_o += 1 each cycle stall_f_o is high.
  - flush_cnt_o += 1 each accepted redirect.
  - Both saturate at 2^CNT_W-1.
- Reset mid-WAIT returns the FSM to IDLE and clears the timer, counters and error.

Test Plan:
- add x5 in MEM, add x5 in WB, sub in EX reads rs1=x5 -> fwd_a_o=10. Next cycle with x5 only in WB -> fwd_a_o=01.
- lw x6 in EX, ID reads rs2=x6 (FWD_EN=1) -> one cycle of stall_f/d=1, flush_e=1. Next cycle fwd_b_o=01 and no stall. stall_cnt_o=1.
- FWD_EN=0: addi x7 in EX, ID reads x7 -> stall for 3 cycles (EX, MEM, WB), then released. stall_cnt_o=3.
- redirect_m_i=1 while haz is true -> flush_d/e/m=1, stall_f=0, flush_cnt_o=1.
- dmem_req=1 with ready low for 4 cycles -> stall_f/d/e/m and flush_w high for 4 cycles, released on the ready cycle. A redirect held throughout flushes only on the ready cycle.
- TIMEOUT=4 with ready held low -> mem_err_o=1 after 4 cycles, then stays 1 after ready. rst_ni low mid-WAIT -> all registered state cleared immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : RV32I 5-stage hazard unit: forwarding, RAW stalls, redirect
//            flushes, data-memory wait FSM with timeout and perf counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int FWD_EN  = 1,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] rs1_d_i,
  input  logic [REG_AW-1:0] rs2_d_i,
  input  logic [REG_AW-1:0] rs1_e_i,
  input  logic [REG_AW-1:0] rs2_e_i,
  input  logic [REG_AW-1:0] rd_e_i,
  input  logic              regwrite_e_i,
  input  logic              memread_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              regwrite_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              regwrite_w_i,
  input  logic              redirect_m_i,
  input  logic              dmem_req_m_i,
  input  logic              dmem_ready_m_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              stall_e_o,
  output logic              stall_m_o,
  output logic              flush_d_o,
  output logic              flush_e_o,
  output logic              flush_m_o,
  output logic              flush_w_o,
  output logic              mem_err_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam int               c_TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TW-1:0]  c_T_ERR   = c_TW'(TIMEOUT - 2);
  localparam logic [c_TW-1:0]  c_T_MAX   = c_TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  logic [c_TW-1:0]  r_timer;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_haz;
  logic       w_mwait;
  logic       w_redirect;

  // x0 is hardwired zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  generate
    if (FWD_EN != 0) begin : g_fwd
      logic w_unused_fwd;
      assign w_unused_fwd = regwrite_e_i;

      always_comb begin
        w_fwd_a = 2'b00;
        if (regwrite_m_i && reg_match(rd_m_i, rs1_e_i))      w_fwd_a = 2'b10;
        else if (regwrite_w_i && reg_match(rd_w_i, rs1_e_i)) w_fwd_a = 2'b01;
        w_fwd_b = 2'b00;
        if (regwrite_m_i && reg_match(rd_m_i, rs2_e_i))      w_fwd_b = 2'b10;
        else if (regwrite_w_i && reg_match(rd_w_i, rs2_e_i)) w_fwd_b = 2'b01;
      end

      assign w_haz = memread_e_i &&
                     (reg_match(rd_e_i, rs1_d_i) || reg_match(rd_e_i, rs2_d_i));
    end else begin : g_nofwd
      logic w_unused_nofwd;
      assign w_unused_nofwd = ^{rs1_e_i, rs2_e_i, memread_e_i};

      assign w_fwd_a = 2'b00;
      assign w_fwd_b = 2'b00;
      assign w_haz   = (regwrite_e_i && (reg_match(rd_e_i, rs1_d_i) || reg_match(rd_e_i, rs2_d_i)))
                    || (regwrite_m_i && (reg_match(rd_m_i, rs1_d_i) || reg_match(rd_m_i, rs2_d_i)))
                    || (regwrite_w_i && (reg_match(rd_w_i, rs1_d_i) || reg_match(rd_w_i, rs2_d_i)));
    end
  endgenerate

  assign w_mwait    = dmem_req_m_i && !dmem_ready_m_i;
  assign w_redirect = redirect_m_i && !w_mwait;

  // Memory wait dominates, then redirect (the stalled instruction dies), then RAW.
  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    stall_m_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    flush_m_o = 1'b0;
    flush_w_o = 1'b0;
    if (w_mwait) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      stall_m_o = 1'b1;
      flush_w_o = 1'b1;
    end else if (redirect_m_i) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
      flush_m_o = 1'b1;
    end else if (w_haz) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
    end
  end

  assign fwd_a_o = w_fwd_a;
  assign fwd_b_o = w_fwd_b;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_mem_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mwait) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dmem_ready_m_i) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
          end else begin
            if (r_timer != c_T_MAX) r_timer <= r_timer + 1'b1;
            if (r_timer == c_T_ERR) r_mem_err <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_f_o && (r_stall_cnt != c_CNT_MAX)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_redirect && (r_flush_cnt != c_CNT_MAX)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign mem_err_o   = r_mem_err;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Bench for pipe_hazard_ctrl, forwarding and non-forwarding builds
//            side by side against a rule-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic regwrite_e, memread_e, regwrite_m, regwrite_w;
  logic redirect, dmem_req, dmem_ready;

  logic [1:0]    fwd_a_1, fwd_b_1, fwd_a_0, fwd_b_0;
  logic          stall_f_1, stall_d_1, stall_e_1, stall_m_1;
  logic          flush_d_1, flush_e_1, flush_m_1, flush_w_1;
  logic          stall_f_0, stall_d_0, stall_e_0, stall_m_0;
  logic          flush_d_0, flush_e_0, flush_m_0, flush_w_0;
  logic          err_1, err_0;
  logic [CW-1:0] scnt_1, fcnt_1, scnt_0, fcnt_0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(AW), .FWD_EN(1), .TIMEOUT(TO), .CNT_W(CW)) u_fwd (
    .clk_i(clk), .rst_ni(rst_n),
    .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e),
    .rd_e_i(rd_e), .regwrite_e_i(regwrite_e), .memread_e_i(memread_e),
    .rd_m_i(rd_m), .regwrite_m_i(regwrite_m), .rd_w_i(rd_w), .regwrite_w_i(regwrite_w),
    .redirect_m_i(redirect), .dmem_req_m_i(dmem_req), .dmem_ready_m_i(dmem_ready),
    .fwd_a_o(fwd_a_1), .fwd_b_o(fwd_b_1),
    .stall_f_o(stall_f_1), .stall_d_o(stall_d_1), .stall_e_o(stall_e_1), .stall_m_o(stall_m_1),
    .flush_d_o(flush_d_1), .flush_e_o(flush_e_1), .flush_m_o(flush_m_1), .flush_w_o(flush_w_1),
    .mem_err_o(err_1), .stall_cnt_o(scnt_1), .flush_cnt_o(fcnt_1)
  );

  pipe_hazard_ctrl #(.REG_AW(AW), .FWD_EN(0), .TIMEOUT(TO), .CNT_W(CW)) u_nofwd (
    .clk_i(clk), .rst_ni(rst_n),
    .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e),
    .rd_e_i(rd_e), .regwrite_e_i(regwrite_e), .memread_e_i(memread_e),
    .rd_m_i(rd_m), .regwrite_m_i(regwrite_m), .rd_w_i(rd_w), .regwrite_w_i(regwrite_w),
    .redirect_m_i(redirect), .dmem_req_m_i(dmem_req), .dmem_ready_m_i(dmem_ready),
    .fwd_a_o(fwd_a_0), .fwd_b_o(fwd_b_0),
    .stall_f_o(stall_f_0), .stall_d_o(stall_d_0), .stall_e_o(stall_e_0), .stall_m_o(stall_m_0),
    .flush_d_o(flush_d_0), .flush_e_o(flush_e_0), .flush_m_o(flush_m_0), .flush_w_o(flush_w_0),
    .mem_err_o(err_0), .stall_cnt_o(scnt_0), .flush_cnt_o(fcnt_0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic dep(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic logic [1:0] efwd(input int fe, input logic [AW-1:0] rs);
    if (fe == 0) return 2'd0;
    if (regwrite_m && dep(rd_m, rs)) return 2'd2;
    if (regwrite_w && dep(rd_w, rs)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic ehaz(input int fe);
    logic src_hit_e, src_hit_m, src_hit_w;
    src_hit_e = dep(rd_e, rs1_d) || dep(rd_e, rs2_d);
    src_hit_m = dep(rd_m, rs1_d) || dep(rd_m, rs2_d);
    src_hit_w = dep(rd_w, rs1_d) || dep(rd_w, rs2_d);
    if (fe != 0) return memread_e && src_hit_e;
    return (regwrite_e && src_hit_e) || (regwrite_m && src_hit_m) || (regwrite_w && src_hit_w);
  endfunction

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}
  function automatic logic [7:0] eflags(input int fe);
    logic mw;
    mw = dmem_req && !dmem_ready;
    if (mw)       return 8'b1111_0001;
    if (redirect) return 8'b0000_1110;
    if (ehaz(fe)) return 8'b1100_0100;
    return 8'b0000_0000;
  endfunction

  int m_scnt [2];
  int m_fcnt;
  int m_n;
  bit m_inw;
  bit m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_scnt[0] <= 0;
      m_scnt[1] <= 0;
      m_fcnt    <= 0;
      m_n       <= 0;
      m_inw     <= 1'b0;
      m_err     <= 1'b0;
    end else begin
      logic [7:0] fl;
      logic mw;
      mw = dmem_req && !dmem_ready;
      for (int fe = 0; fe < 2; fe++) begin
        fl = eflags(fe);
        if (fl[7] && m_scnt[fe] < CMAX) m_scnt[fe] <= m_scnt[fe] + 1;
      end
      if (redirect && !mw && m_fcnt < CMAX) m_fcnt <= m_fcnt + 1;
      // A wait episode lasts from the first stalled cycle until ready.
      if (!m_inw) begin
        if (mw) begin
          m_inw <= 1'b1;
          m_n   <= 1;
          if (1 >= TO) m_err <= 1'b1;
        end
      end else if (dmem_ready) begin
        m_inw <= 1'b0;
      end else begin
        m_n <= m_n + 1;
        if (m_n + 1 >= TO) m_err <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("dut_fwd", 32'({fwd_a_1, fwd_b_1, stall_f_1, stall_d_1, stall_e_1, stall_m_1,
                        flush_d_1, flush_e_1, flush_m_1, flush_w_1, err_1, scnt_1, fcnt_1}),
                   32'({efwd(1, rs1_e), efwd(1, rs2_e), eflags(1), m_err,
                        CW'(m_scnt[1]), CW'(m_fcnt)}));
    chk("dut_nofwd", 32'({fwd_a_0, fwd_b_0, stall_f_0, stall_d_0, stall_e_0, stall_m_0,
                          flush_d_0, flush_e_0, flush_m_0, flush_w_0, err_0, scnt_0, fcnt_0}),
                     32'({efwd(0, rs1_e), efwd(0, rs2_e), eflags(0), m_err,
                          CW'(m_scnt[0]), CW'(m_fcnt)}));
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
    rd_e = '0; rd_m = '0; rd_w = '0;
    regwrite_e = 1'b0; memread_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
    redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    nxt();
    nxt();
    chk("reset_err", 32'(err_1), 32'd0);
    chk("reset_scnt", 32'(scnt_1), 32'd0);
    chk("reset_fcnt", 32'(fcnt_0), 32'd0);
    rst_n = 1'b1;

    // MEM has priority over WB, then WB alone
    rs1_e = 5; rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1;
    @(negedge clk);
    chk("fwd_a_mem", 32'(fwd_a_1), 32'd2);
    chk("fwd_a_nofwd", 32'(fwd_a_0), 32'd0);
    nxt();
    regwrite_m = 0; rd_m = 0;
    @(negedge clk);
    chk("fwd_a_wb", 32'(fwd_a_1), 32'd1);

    // load-use: one stall, then WB forward
    do_reset();
    memread_e = 1; regwrite_e = 1; rd_e = 6; rs2_d = 6;
    @(negedge clk);
    chk("lu_stall", 32'({stall_f_1, stall_d_1, flush_e_1, stall_e_1}), 32'b1110);
    nxt();
    clear_in();
    regwrite_w = 1; rd_w = 6; rs2_e = 6;
    @(negedge clk);
    chk("lu_fwd_b", 32'(fwd_b_1), 32'd1);
    chk("lu_release", 32'(stall_f_1), 32'd0);
    chk("lu_scnt", 32'(scnt_1), 32'd1);

    // no forwarding: writer walks EX, MEM, WB -> three stalls
    do_reset();
    rs1_d = 7;
    for (int s = 0; s < 3; s++) begin
      regwrite_e = (s == 0); rd_e = (s == 0) ? 5'd7 : 5'd0;
      regwrite_m = (s == 1); rd_m = (s == 1) ? 5'd7 : 5'd0;
      regwrite_w = (s == 2); rd_w = (s == 2) ? 5'd7 : 5'd0;
      @(negedge clk);
      chk("nf_stall", 32'(stall_f_0), 32'd1);
      nxt();
    end
    regwrite_w = 0; rd_w = 0;
    @(negedge clk);
    chk("nf_release", 32'(stall_f_0), 32'd0);
    chk("nf_scnt0", 32'(scnt_0), 32'd3);
    chk("nf_scnt1", 32'(scnt_1), 32'd0);

    // redirect beats a load-use hazard
    do_reset();
    memread_e = 1; regwrite_e = 1; rd_e = 6; rs2_d = 6; redirect = 1;
    @(negedge clk);
    chk("rd_flush", 32'({flush_d_1, flush_e_1, flush_m_1, stall_f_1}), 32'b1110);
    nxt();
    clear_in();
    @(negedge clk);
    chk("rd_fcnt", 32'(fcnt_1), 32'd1);

    // 4-cycle memory wait with held redirect; timeout at 4
    do_reset();
    dmem_req = 1; redirect = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mw_flags", 32'({stall_f_1, stall_d_1, stall_e_1, stall_m_1,
                           flush_d_1, flush_e_1, flush_m_1, flush_w_1}), 32'b1111_0001);
      nxt();
    end
    dmem_ready = 1;
    @(negedge clk);
    chk("mw_ready", 32'({stall_f_1, flush_d_1, err_1}), 32'b011);
    nxt();
    clear_in();
    @(negedge clk);
    chk("mw_cnts", 32'({scnt_1, fcnt_1}), 32'({4'd4, 4'd1}));
    chk("mw_err_sticky", 32'(err_1), 32'd1);

    // saturation, then async reset mid-wait
    do_reset();
    dmem_req = 1;
    repeat (20) nxt();
    chk("sat_scnt", 32'(scnt_1), 32'd15);
    chk("wait_err", 32'(err_0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_clear", 32'({err_1, scnt_1, fcnt_1, err_0, scnt_0}), 32'd0);
    nxt();
    clear_in();
    rst_n = 1'b1;

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      nxt();
      if (c % 250 == 249) begin
        rst_n = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      rs1_d = AW'($urandom_range(0, 3)); rs2_d = AW'($urandom_range(0, 3));
      rs1_e = AW'($urandom_range(0, 3)); rs2_e = AW'($urandom_range(0, 3));
      rd_e  = AW'($urandom_range(0, 3)); rd_m  = AW'($urandom_range(0, 3));
      rd_w  = AW'($urandom_range(0, 3));
      regwrite_e = $urandom_range(0, 1) == 1;
      memread_e  = $urandom_range(0, 2) == 0;
      regwrite_m = $urandom_range(0, 1) == 1;
      regwrite_w = $urandom_range(0, 1) == 1;
      redirect   = $urandom_range(0, 7) == 0;
      dmem_req   = $urandom_range(0, 2) == 0;
      dmem_ready = $urandom_range(0, 2) != 0;
    end
    nxt();
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
